// File: rtl/mmio_peripheral_responder.sv
// Memory-mapped responder for the MEM-stage data bus: a reload timer, LED and 7-segment registers
// and a free-running systick, all in one 32-byte window.
module mmio_peripheral_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        irq,
    output logic [7:0]  leds,
    output logic [11:0] digits
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        REG_TH      = 3'd0,
        REG_TL      = 3'd1,
        REG_TCON    = 3'd2,
        REG_LEDS    = 3'd3,
        REG_DIGITS  = 3'd4,
        REG_SYSTICK = 3'd5,
        REG_RSVD0   = 3'd6,
        REG_RSVD1   = 3'd7
    } reg_sel_e;

    logic [31:0]   th_q, th_d;
    logic [31:0]   tl_q, tl_d;
    logic [2:0]    tcon_q, tcon_d;
    logic [7:0]    leds_q, leds_d;
    logic [11:0]   digits_q, digits_d;
    logic [31:0]   systick_q, systick_d;
    logic [PW-1:0] pcnt_q, pcnt_d;

    reg_sel_e sel;
    logic     wr_en;
    logic     tick;
    logic     overflow;
    logic     ovf_set;

    // Byte lanes are not decoded; every access is treated as a full word.
    logic unused_byte_lane;
    assign unused_byte_lane = ^address[1:0];

    // The window is 32-byte aligned, so the decode is a compare of the upper 27 bits.
    assign hit   = (address[31:5] == BASE_ADDR[31:5]);
    assign sel   = reg_sel_e'(address[4:2]);
    assign wr_en = MemWrite && hit;

    always_comb begin
        pcnt_d = pcnt_q;
        tick   = 1'b0;
        if (tcon_q[0]) begin
            if (pcnt_q == PLAST) begin
                tick   = 1'b1;
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
    end

    assign overflow = tick && (tl_q == 32'hFFFF_FFFF);
    assign ovf_set  = overflow && tcon_q[1];

    // CPU writes are applied after the timer update so they win over a same-edge tick.
    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        leds_d    = leds_q;
        digits_d  = digits_q;
        systick_d = systick_q + 32'd1;

        if (tick) begin
            tl_d = overflow ? th_q : tl_q + 32'd1;
        end
        if (ovf_set) begin
            tcon_d[2] = 1'b1;
        end

        if (wr_en) begin
            case (sel)
                REG_TH:     th_d     = write_data;
                REG_TL:     tl_d     = write_data;
                REG_TCON:   tcon_d   = {write_data[2] | ovf_set, write_data[1:0]};
                REG_LEDS:   leds_d   = write_data[7:0];
                REG_DIGITS: digits_d = write_data[11:0];
                default:    ;
            endcase
        end
    end

    always_comb begin
        read_data = '0;
        if (MemRead && hit) begin
            case (sel)
                REG_TH:      read_data = th_q;
                REG_TL:      read_data = tl_q;
                REG_TCON:    read_data = {29'd0, tcon_q};
                REG_LEDS:    read_data = {24'd0, leds_q};
                REG_DIGITS:  read_data = {20'd0, digits_q};
                REG_SYSTICK: read_data = systick_q;
                default:     read_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            leds_q    <= '0;
            digits_q  <= '0;
            systick_q <= '0;
            pcnt_q    <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            leds_q    <= leds_d;
            digits_q  <= digits_d;
            systick_q <= systick_d;
            pcnt_q    <= pcnt_d;
        end
    end

    assign irq    = tcon_q[2];
    assign leds   = leds_q;
    assign digits = digits_q;

endmodule
